// File: rtl/cc_speed_meter.sv
// cc_speed_meter: counts rising edges of an asynchronous sensor over a fixed
// gate window of clock cycles and publishes the saturating count, a one-cycle
// new-sample strobe and a sticky overflow flag at each window close.
module cc_speed_meter #(
  parameter int unsigned SPEEDMETER_DATAWIDTH    = 8,
  parameter int unsigned SPEEDMETER_WINDOWWIDTH  = 24,
  parameter int unsigned SPEEDMETER_WINDOWCYCLES = 5000000
) (
  input  logic                            CC_SPEEDMETER_CLOCK_50,
  input  logic                            CC_SPEEDMETER_RESET_InHigh,
  input  logic                            CC_SPEEDMETER_enable_InHigh,
  input  logic                            CC_SPEEDMETER_sensor_In,
  output logic [SPEEDMETER_DATAWIDTH-1:0] CC_SPEEDMETER_data_OutBUS,
  output logic                            CC_SPEEDMETER_newData_OutHigh,
  output logic                            CC_SPEEDMETER_overflow_OutHigh
);

  localparam logic [SPEEDMETER_WINDOWWIDTH-1:0] WINDOW_LAST =
    SPEEDMETER_WINDOWWIDTH'(SPEEDMETER_WINDOWCYCLES - 1);
  localparam logic [SPEEDMETER_WINDOWWIDTH-1:0] WINDOW_ONE =
    SPEEDMETER_WINDOWWIDTH'(1);
  localparam logic [SPEEDMETER_DATAWIDTH-1:0] COUNT_ONE =
    SPEEDMETER_DATAWIDTH'(1);

  logic                              sensorSync1;
  logic                              sensorSync2;
  logic                              sensorHist;
  logic                              sensorEdge;

  logic [SPEEDMETER_WINDOWWIDTH-1:0] windowCount;
  logic                              windowLast;

  logic [SPEEDMETER_DATAWIDTH-1:0]   pulseCount;
  logic                              pulseSticky;
  logic                              pulseFull;

  logic [SPEEDMETER_DATAWIDTH-1:0]   closeData;
  logic                              closeOverflow;

  // Two-flop synchronizer plus history flop; runs regardless of enable so
  // re-enabling with the sensor already high does not fake an edge.
  always_ff @(posedge CC_SPEEDMETER_CLOCK_50 or posedge CC_SPEEDMETER_RESET_InHigh) begin
    if (CC_SPEEDMETER_RESET_InHigh) begin
      sensorSync1 <= 1'b0;
      sensorSync2 <= 1'b0;
      sensorHist  <= 1'b0;
    end else begin
      sensorSync1 <= CC_SPEEDMETER_sensor_In;
      sensorSync2 <= sensorSync1;
      sensorHist  <= sensorSync2;
    end
  end

  assign sensorEdge = sensorSync2 & ~sensorHist;

  // A disable in the terminal cycle suppresses the close entirely.
  assign windowLast = CC_SPEEDMETER_enable_InHigh && (windowCount == WINDOW_LAST);
  assign pulseFull  = &pulseCount;

  // Gate-window cycle counter: 0..WINDOWCYCLES-1, held at 0 while disabled.
  always_ff @(posedge CC_SPEEDMETER_CLOCK_50 or posedge CC_SPEEDMETER_RESET_InHigh) begin
    if (CC_SPEEDMETER_RESET_InHigh) begin
      windowCount <= '0;
    end else if (!CC_SPEEDMETER_enable_InHigh || windowLast) begin
      windowCount <= '0;
    end else begin
      windowCount <= windowCount + WINDOW_ONE;
    end
  end

  // Saturating pulse counter with sticky overflow; restarts at every close so
  // an edge in the terminal cycle is credited only to the closing window.
  always_ff @(posedge CC_SPEEDMETER_CLOCK_50 or posedge CC_SPEEDMETER_RESET_InHigh) begin
    if (CC_SPEEDMETER_RESET_InHigh) begin
      pulseCount  <= '0;
      pulseSticky <= 1'b0;
    end else if (!CC_SPEEDMETER_enable_InHigh || windowLast) begin
      pulseCount  <= '0;
      pulseSticky <= 1'b0;
    end else if (sensorEdge) begin
      if (pulseFull) begin
        pulseSticky <= 1'b1;
      end else begin
        pulseCount <= pulseCount + COUNT_ONE;
      end
    end
  end

  // Closing value: running count plus any edge seen in the terminal cycle.
  always_comb begin
    closeData     = pulseCount;
    closeOverflow = pulseSticky;
    if (sensorEdge) begin
      if (pulseFull) begin
        closeOverflow = 1'b1;
      end else begin
        closeData = pulseCount + COUNT_ONE;
      end
    end
  end

  // Publish register: data and overflow only move on the strobe cycle.
  always_ff @(posedge CC_SPEEDMETER_CLOCK_50 or posedge CC_SPEEDMETER_RESET_InHigh) begin
    if (CC_SPEEDMETER_RESET_InHigh) begin
      CC_SPEEDMETER_data_OutBUS      <= '0;
      CC_SPEEDMETER_newData_OutHigh  <= 1'b0;
      CC_SPEEDMETER_overflow_OutHigh <= 1'b0;
    end else begin
      CC_SPEEDMETER_newData_OutHigh <= windowLast;
      if (windowLast) begin
        CC_SPEEDMETER_data_OutBUS      <= closeData;
        CC_SPEEDMETER_overflow_OutHigh <= closeOverflow;
      end
    end
  end

endmodule
